ray_dir_normalize: RTL
======================

Name: ray_dir_normalize

Overview:
- Downstream consumer of inv_sqrt in the ray marcher direction path.
- Buffers raw Q8.24 ray-direction vectors while inv_sqrt computes 1/sqrt(x²+y²+z²), then pairs each vector with its inv_sqrt result in arrival order.
- Scales the three components by a single time-shared multiplier.
- Presents the unit direction vector to the march-step stage with a valid/ready handshake.

Parameters:
- WIDTH, 32: component and inv_sqrt word width; fixed-point Q8.24 signed, so fractional bits = WIDTH-8.
- DEPTH, 4: entries in each of the vector FIFO and the inv_sqrt FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- vec_valid_in  in  1  raw vector presented
- vec_ready  out  1  vector FIFO not full; transfer when vec_valid_in && vec_ready
- vec_x_in, vec_y_in, vec_z_in  in  WIDTH each  raw direction components, signed Q8.24
- isq_valid_in  in  1  inv_sqrt valid_out; no backpressure possible
- isq_in  in  WIDTH  inv_sqrt result, unsigned Q8.24
- out_valid  out  1  normalized vector valid
- out_ready  in  1  consumer accepts
- out_x, out_y, out_z  out  WIDTH each  normalized components, signed Q8.24
- err_overflow  out  1  sticky: isq_valid_in seen while inv_sqrt FIFO full
- err_orphan  out  1  sticky: inv_sqrt result popped with no matching vector

Behaviour:
- Reset: both FIFOs empty, FSM in IDLE, all outputs 0 except vec_ready=1; sticky flags cleared. Reset mid-operation discards all buffered data and any in-flight multiply.
- Vector FIFO push: on vec_valid_in && vec_ready.
- Inv_sqrt FIFO push: on every isq_valid_in. If that FIFO is full, the result is dropped and err_overflow is set.
- Simultaneous push and pop on the same FIFO in one cycle is legal; occupancy is unchanged.
- FSM states: IDLE, MUL_X, MUL_Y, MUL_Z, OUT.
  - IDLE: if both FIFOs are non-empty, pop one entry from each, latch the vector and isq, go to MUL_X.
  - IDLE: if the isq FIFO is non-empty and the vector FIFO is empty, pop and discard the isq entry, set err_orphan, stay in IDLE.
  - MUL_X, MUL_Y, MUL_Z: one cycle each; compute the component into its output register.
  - OUT: out_valid=1, outputs held stable until out_ready; on handshake, clear out_valid and go to IDLE.
- Latency: out_valid asserts 4 cycles after the IDLE pop cycle. Minimum initiation interval is 5 cycles.
- Arithmetic per component:
  - Signed WIDTH x zero-extended WIDTH gives a 2*WIDTH product.
  - Shift arithmetic right by 24.
  - Saturate to [0x80000000, 0x7FFFFFFF].
- Pairing is strictly FIFO order; vectors and isq results must be issued to inv_sqrt in the same order.

Optional Feature:
- RAYNORM_ROUND_EN defined: add 2^23 to the product before the shift (round half up), then saturate.
- Not defined: truncate by plain arithmetic shift.

Decomposition:
- Package ray_pkg holds:
  - the fixed-point typedef fix_t (logic signed [31:0]);
  - the constant FRAC_BITS = 24;
  - a vec3_t struct {x, y, z};
  - the normalize FSM state enum.
- Sub-module sync_fifo (WIDTH, DEPTH; push, pop, full, empty, data):
  - instantiated twice, the vector instance 3*WIDTH wide and the isq instance WIDTH wide.
  - Use a wrap-around pointer with an extra MSB to separate full from empty.

Test Plan:
- Basic scaling: vec (0x03000000, 0, 0x04000000), then isq 0x00333333 two cycles later, out_ready=1 -> out (0x00999999, 0, 0x00CCCCCC), out_valid exactly 4 cycles after the pop.
- Signed component: vec_x 0xFD000000 with isq 0x00333333 -> out_x 0xFF666667.
- Saturation: vec_x 0x7F000000 with isq 0x02000000 -> out_x 0x7FFFFFFF; vec_x 0x81000000 with the same isq -> out_x 0x80000000; no flags set.
- Backpressure and ordering:
  - Push 4 vectors and 4 isq values with out_ready=0 -> vec_ready=0 after the 5th-cycle fill, and outputs stay held.
  - Then release out_ready -> 4 results emerge in push order, each 5 cycles apart.
- Error flags:
  - An isq pulse with no vector pushed -> err_orphan=1 and stays set.
  - 5 isq pulses while the FSM is stalled in OUT -> err_overflow=1 and the 5th value is lost.
- Reset mid-op: assert rst during MUL_Y -> next cycle out_valid=0, vec_ready=1, flags 0, and a following vector plus isq pair processes normally.

Source files
------------

// File: rtl/ray_pkg.sv
// Shared fixed-point types, vector struct and normalize FSM states for the ray direction path.
// Q8.24 signed components; the state enum is consumed by ray_dir_normalize.
package ray_pkg;

  localparam int FRAC_BITS = 24;

  typedef logic signed [31:0] fix_t;

  typedef struct packed {
    fix_t x;
    fix_t y;
    fix_t z;
  } vec3_t;

  typedef enum logic [2:0] {
    IDLE,
    MUL_X,
    MUL_Y,
    MUL_Z,
    OUT
  } norm_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, first-word fall-through read, pointers carry an extra wrap bit.
// Push while full and pop while empty are ignored; simultaneous push/pop keeps occupancy.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/ray_dir_normalize.sv
// Pairs buffered ray vectors with inv_sqrt results in order and scales x,y,z through one shared multiplier.
// Define RAYNORM_ROUND_EN to round half up before the Q8.24 shift; otherwise the product is truncated.
module ray_dir_normalize
  import ray_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vec_valid_in,
  output logic             vec_ready,
  input  logic [WIDTH-1:0] vec_x_in,
  input  logic [WIDTH-1:0] vec_y_in,
  input  logic [WIDTH-1:0] vec_z_in,
  input  logic             isq_valid_in,
  input  logic [WIDTH-1:0] isq_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_z,
  output logic             err_overflow,
  output logic             err_orphan
);

  logic                   vec_full, vec_empty, isq_full, isq_empty;
  logic                   vec_pop, isq_pop;
  logic [3*WIDTH-1:0]     vec_fifo_dat;
  logic [WIDTH-1:0]       isq_fifo_dat;

  norm_state_e            state_q;
  vec3_t                  vec_q, out_q;
  logic [WIDTH-1:0]       isq_q;
  logic                   out_valid_q, err_overflow_q, err_orphan_q;

  logic signed [WIDTH-1:0]   mul_a;
  logic signed [2*WIDTH-1:0] prod, prod_r, shifted;
  logic [WIDTH-1:0]          sat;

  sync_fifo #(.WIDTH(3*WIDTH), .DEPTH(DEPTH)) u_vec_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (vec_valid_in),
    .pop_i   (vec_pop),
    .data_i  ({vec_x_in, vec_y_in, vec_z_in}),
    .data_o  (vec_fifo_dat),
    .full_o  (vec_full),
    .empty_o (vec_empty)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_isq_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (isq_valid_in),
    .pop_i   (isq_pop),
    .data_i  (isq_in),
    .data_o  (isq_fifo_dat),
    .full_o  (isq_full),
    .empty_o (isq_empty)
  );

  // An isq entry is always consumed in IDLE: paired if a vector waits, otherwise discarded as an orphan.
  assign vec_ready = !vec_full;
  assign isq_pop   = (state_q == IDLE) && !isq_empty;
  assign vec_pop   = isq_pop && !vec_empty;

  always_comb begin
    mul_a = vec_q.x;
    case (state_q)
      MUL_Y:   mul_a = vec_q.y;
      MUL_Z:   mul_a = vec_q.z;
      default: mul_a = vec_q.x;
    endcase
  end

  assign prod = $signed({{WIDTH{mul_a[WIDTH-1]}}, mul_a}) * $signed({{WIDTH{1'b0}}, isq_q});

`ifdef RAYNORM_ROUND_EN
  localparam logic signed [2*WIDTH-1:0] HALF_LSB = (2*WIDTH)'(1) <<< (FRAC_BITS - 1);
  assign prod_r = prod + HALF_LSB;
`else
  assign prod_r = prod;
`endif

  assign shifted = prod_r >>> FRAC_BITS;

  // In range only if every bit above the result's sign bit matches the product sign.
  always_comb begin
    sat = shifted[WIDTH-1:0];
    if (!shifted[2*WIDTH-1] && (|shifted[2*WIDTH-2:WIDTH-1])) begin
      sat = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (shifted[2*WIDTH-1] && !(&shifted[2*WIDTH-2:WIDTH-1])) begin
      sat = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      vec_q          <= '0;
      isq_q          <= '0;
      out_q          <= '0;
      out_valid_q    <= 1'b0;
      err_overflow_q <= 1'b0;
      err_orphan_q   <= 1'b0;
    end else begin
      if (isq_valid_in && isq_full) err_overflow_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (vec_pop) begin
            vec_q   <= vec_fifo_dat;
            isq_q   <= isq_fifo_dat;
            state_q <= MUL_X;
          end else if (isq_pop) begin
            err_orphan_q <= 1'b1;
          end
        end
        MUL_X: begin
          out_q.x <= sat;
          state_q <= MUL_Y;
        end
        MUL_Y: begin
          out_q.y <= sat;
          state_q <= MUL_Z;
        end
        MUL_Z: begin
          out_q.z     <= sat;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign out_x        = out_q.x;
  assign out_y        = out_q.y;
  assign out_z        = out_q.z;
  assign err_overflow = err_overflow_q;
  assign err_orphan   = err_orphan_q;

endmodule
